// File: rtl/seg7_capture_decoder_if.sv
// seg7_capture_decoder_if
//   Bundles the snooped 7-segment bus and the decoded readback outputs.
//   master : the side driving the display bus and reading decoded results
//   slave  : the capture decoder itself
// Signals
//   seg_n        7            segments, 0 = lit; bit0=a .. bit5=f, bit6=g
//   digit_en     NUM_DIGITS   one-hot digit strobe
//   digits       4*NUM_DIGITS decoded codes, digit i at [4i+3:4i]
//   digit_valid  NUM_DIGITS   digit i holds a committed legal code
//   bad_pattern  1            sticky illegal-pattern flag
//   update       1            one-cycle pulse when a committed digit changed
//   upd_idx      IDX_W        index of the digit changed by the last update
interface seg7_capture_decoder_if #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2
);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    bad_pattern;
  logic                    update;
  logic [IDX_W-1:0]        upd_idx;

  modport master (
    output seg_n, digit_en,
    input  digits, digit_valid, bad_pattern, update, upd_idx
  );

  modport slave (
    input  seg_n, digit_en,
    output digits, digit_valid, bad_pattern, update, upd_idx
  );
endinterface

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder
//   Snoops a multiplexed active-low 7-segment bus and recovers the per-digit
//   codes (0-9, 10 = blank, 15 = illegal). A (strobe, segment) pair must be
//   seen unchanged for STABLE_CYCLES samples before it is committed.
// Ports
//   clk    system clock, everything on posedge
//   rst_n  synchronous reset, active-low
//   bus    slave side of seg7_capture_decoder_if (bus in, decoded results out)
module seg7_capture_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = 2
) (
  input  logic clk,
  input  logic rst_n,
  seg7_capture_decoder_if.slave bus
);
  localparam int SAMP_W = NUM_DIGITS + 7;
  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // samp_reg is the registered bus; ref_reg is the sample the FSM saw the
  // previous cycle, so stability is judged purely on registered values.
  logic [SAMP_W-1:0]       samp_reg;
  logic [SAMP_W-1:0]       ref_reg;
  logic [1:0]              state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next, cnt_run;
  logic                    bad_reg;
  logic                    update_reg, update_next;
  logic [IDX_W-1:0]        upd_idx_reg, upd_idx_next;
  logic                    commit;
  logic [IDX_W-1:0]        sel_idx;
  logic [3:0]              code;
  logic [4*NUM_DIGITS-1:0] digits_all;
  logic [NUM_DIGITS-1:0]   valid_all;

  logic [NUM_DIGITS-1:0]   samp_en;
  logic [6:0]              samp_seg;
  logic                    samp_onehot;

  assign samp_en     = samp_reg[SAMP_W-1:7];
  assign samp_seg    = samp_reg[6:0];
  assign samp_onehot = (samp_en != '0) && ((samp_en & (samp_en - 1'b1)) == '0);

  function automatic logic [3:0] decode7(input logic [6:0] lit);
    case (lit)
      7'b0111111: decode7 = 4'd0;
      7'b0000110: decode7 = 4'd1;
      7'b1011011: decode7 = 4'd2;
      7'b1001111: decode7 = 4'd3;
      7'b1100110: decode7 = 4'd4;
      7'b1101101: decode7 = 4'd5;
      7'b1111101: decode7 = 4'd6;
      7'b0000111: decode7 = 4'd7;
      7'b1111111: decode7 = 4'd8;
      7'b1101111: decode7 = 4'd9;
      7'b0000000: decode7 = 4'd10;
      default:    decode7 = 4'd15;
    endcase
  endfunction

  assign code = decode7(~samp_seg);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (samp_en[i]) sel_idx = IDX_W'(i);
    end
  end

  // Stability FSM
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cnt_run    = CNT_W'(1);
    commit     = 1'b0;
    if (!samp_onehot) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else if (state_reg == ST_LOCKED && samp_reg == ref_reg) begin
      state_next = ST_LOCKED;
    end else begin
      // A run continues only while settling on an identical sample; entering
      // from IDLE or after any change restarts the run at 1.
      if (state_reg == ST_SETTLE && samp_reg == ref_reg)
        cnt_run = cnt_reg + CNT_W'(1);
      if (cnt_run >= CNT_W'(STABLE_CYCLES)) begin
        commit     = 1'b1;
        state_next = ST_LOCKED;
        cnt_next   = CNT_W'(STABLE_CYCLES);
      end else begin
        state_next = ST_SETTLE;
        cnt_next   = cnt_run;
      end
    end
  end

  // Update fires only when the committed value differs from what is stored.
  always_comb begin
    update_next  = 1'b0;
    upd_idx_next = upd_idx_reg;
    if (commit &&
        ((digits_all[{sel_idx, 2'b00} +: 4] != code) ||
         (valid_all[sel_idx] != (code != 4'd15)))) begin
      update_next  = 1'b1;
      upd_idx_next = sel_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_reg    <= '0;
      ref_reg     <= '0;
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bad_reg     <= 1'b0;
      update_reg  <= 1'b0;
      upd_idx_reg <= '0;
    end else begin
      samp_reg    <= {bus.digit_en, bus.seg_n};
      ref_reg     <= samp_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      update_reg  <= update_next;
      upd_idx_reg <= upd_idx_next;
      if (commit && code == 4'd15) bad_reg <= 1'b1;
    end
  end

  // Per-digit storage; a commit touches only the strobed digit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] code_reg;
      logic       valid_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          code_reg  <= 4'd10;
          valid_reg <= 1'b0;
        end else if (commit && sel_idx == IDX_W'(gi)) begin
          code_reg  <= code;
          valid_reg <= (code != 4'd15);
        end
      end
      assign digits_all[4*gi +: 4] = code_reg;
      assign valid_all[gi]         = valid_reg;
    end
  endgenerate

  assign bus.digits      = digits_all;
  assign bus.digit_valid = valid_all;
  assign bus.bad_pattern = bad_reg;
  assign bus.update      = update_reg;
  assign bus.upd_idx     = upd_idx_reg;
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb_seg7_capture_decoder
//   Table-driven bench with a scoreboard of expected update pulses plus
//   hand-written reset sequences for seg7_capture_decoder (4 digits, 4 cycles).
module tb_seg7_capture_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_capture_decoder_if #(.NUM_DIGITS(4), .IDX_W(2)) bus ();

  seg7_capture_decoder #(
    .NUM_DIGITS(4), .STABLE_CYCLES(4), .IDX_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    string      name;
    logic [3:0] en;
    logic [6:0] lit;     // g..a, 1 = lit
    int         hold;    // edges the pattern is held
    bit         commit;  // pattern is expected to commit
    int         idx;
    logic [3:0] code;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] code;
  } upd_t;

  upd_t       exp_q[$];
  logic [3:0] m_digits [4];
  logic [3:0] m_valid;
  logic       m_bad;
  int         n_vec = 0;
  int         n_fail = 0;
  vec_t       vecs[$];

  function automatic logic [15:0] model_digits();
    return {m_digits[3], m_digits[2], m_digits[1], m_digits[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_digits[i] = 4'd10;
    m_valid = 4'b0;
    m_bad   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_commit(input int idx, input logic [3:0] code);
    upd_t u;
    logic nv;
    nv = (code != 4'd15);
    if (m_digits[idx] != code || m_valid[idx] != nv) begin
      u.idx = idx;
      u.code = code;
      exp_q.push_back(u);
    end
    m_digits[idx] = code;
    m_valid[idx]  = nv;
    if (code == 4'd15) m_bad = 1'b1;
  endtask

  // One clock edge; outputs sampled 1 time unit after it. Every update pulse
  // is matched against the scoreboard.
  task automatic tick();
    upd_t e;
    @(posedge clk);
    #1;
    if (bus.update === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_update: upd_idx=%0d digits=%h, required no update",
                 bus.upd_idx, bus.digits);
      end else begin
        e = exp_q.pop_front();
        if (bus.upd_idx !== 2'(e.idx) || bus.digits[4*e.idx +: 4] !== e.code) begin
          n_fail++;
          $display("FAIL update_content: upd_idx=%0d code=%0d, required idx=%0d code=%0d",
                   bus.upd_idx, bus.digits[4*e.idx +: 4], e.idx, e.code);
        end
      end
    end else if (bus.update !== 1'b0) begin
      n_vec++;
      n_fail++;
      $display("FAIL update_x: update=%b, required 0 or 1", bus.update);
    end
  endtask

  task automatic check_state(input string name);
    n_vec++;
    if (bus.digits !== model_digits()) begin
      n_fail++;
      $display("FAIL %s digits: got %h, required %h", name, bus.digits, model_digits());
    end
    n_vec++;
    if (bus.digit_valid !== m_valid) begin
      n_fail++;
      $display("FAIL %s digit_valid: got %b, required %b", name, bus.digit_valid, m_valid);
    end
    n_vec++;
    if (bus.bad_pattern !== m_bad) begin
      n_fail++;
      $display("FAIL %s bad_pattern: got %b, required %b", name, bus.bad_pattern, m_bad);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s pending_updates: %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic add(input string name, input logic [3:0] en, input logic [6:0] lit,
                     input int hold, input bit commit, input int idx, input logic [3:0] code);
    vec_t v;
    v.name = name; v.en = en; v.lit = lit; v.hold = hold;
    v.commit = commit; v.idx = idx; v.code = code;
    vecs.push_back(v);
  endtask

  initial begin
    // Lit patterns (g..a) used below:
    //   2=1011011 3=1001111 5=1101101 6=1111101 7=0000111 8=1111111
    //   9=1101111 blank=0000000 illegal=1000000
    add("dig0_two",      4'b0001, 7'b1011011, 14, 1'b1, 0, 4'd2);
    add("glitch_5a",     4'b0010, 7'b1101101,  3, 1'b0, 1, 4'd0);
    add("glitch_8",      4'b0010, 7'b1111111,  1, 1'b0, 1, 4'd0);
    add("glitch_5b",     4'b0010, 7'b1101101,  5, 1'b1, 1, 4'd5);
    add("illegal_dig2",  4'b0100, 7'b1000000,  5, 1'b1, 2, 4'd15);
    add("legal7_dig2",   4'b0100, 7'b0000111,  5, 1'b1, 2, 4'd7);
    add("multihot",      4'b0011, 7'b1111111, 20, 1'b0, 0, 4'd0);
    add("no_strobe",     4'b0000, 7'b1111111, 20, 1'b0, 0, 4'd0);
    add("blank_dig3",    4'b1000, 7'b0000000,  5, 1'b1, 3, 4'd10);
    add("same_two_dig0", 4'b0001, 7'b1011011,  5, 1'b1, 0, 4'd2);
    add("short_three",   4'b0001, 7'b1001111,  3, 1'b0, 0, 4'd0);
    add("six_dig0",      4'b0001, 7'b1111101,  5, 1'b1, 0, 4'd6);

    // Reset held three cycles
    model_reset();
    bus.digit_en = 4'b0;
    bus.seg_n    = 7'h7F;
    rst_n        = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if (bus.digits !== 16'hAAAA || bus.digit_valid !== 4'b0 || bus.update !== 1'b0 ||
        bus.bad_pattern !== 1'b0 || bus.upd_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_values: digits=%h valid=%b upd=%b bad=%b idx=%0d, required AAAA 0 0 0 0",
               bus.digits, bus.digit_valid, bus.update, bus.bad_pattern, bus.upd_idx);
    end
    $display("txn reset: digits=%h valid=%b", bus.digits, bus.digit_valid);
    rst_n = 1'b1;

    // Table
    for (int v = 0; v < vecs.size(); v++) begin
      bus.digit_en = vecs[v].en;
      bus.seg_n    = ~vecs[v].lit;
      if (vecs[v].commit) model_commit(vecs[v].idx, vecs[v].code);
      for (int c = 0; c < vecs[v].hold; c++) tick();
      check_state(vecs[v].name);
      $display("txn %s: en=%b lit=%b hold=%0d digits=%h valid=%b bad=%b",
               vecs[v].name, vecs[v].en, vecs[v].lit, vecs[v].hold,
               bus.digits, bus.digit_valid, bus.bad_pattern);
    end

    // Reset in the middle of settling digit 9 on digit 3
    bus.digit_en = 4'b1000;
    bus.seg_n    = ~7'b1101111;
    tick();
    tick();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    check_state("mid_reset");
    n_vec++;
    if (bus.upd_idx !== 2'd0 || bus.update !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_upd: update=%b upd_idx=%0d, required 0 0", bus.update, bus.upd_idx);
    end
    rst_n = 1'b1;
    model_commit(3, 4'd9);
    for (int i = 0; i < 4; i++) tick();
    n_vec++;
    if (bus.digits !== 16'hAAAA || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL mid_reset_early: digits=%h pending=%0d, required AAAA 1",
               bus.digits, exp_q.size());
    end
    tick();
    check_state("mid_reset_recommit");
    $display("txn mid_reset_recommit: digits=%h valid=%b", bus.digits, bus.digit_valid);

    // Quiet tail: nothing may move
    for (int i = 0; i < 10; i++) tick();
    check_state("tail_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
